// File: rtl/zip_add_arbiter_pkg.sv
// zip_add_arbiter_pkg: shared types and the round-robin and one-hot helper functions for the zip/add arbiter.
package zip_add_arbiter_pkg;

    localparam int MAX_REQ = 32;
    localparam int IDX_W   = $clog2(MAX_REQ);

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++)
            if (oh[k]) r = IDX_W'(k);
        return r;
    endfunction

    // Scans offsets high to low so the smallest offset from ptr is the one left standing.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] elig, input int n, input int ptr);
        pick_t p;
        int    i;
        p = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            i = (ptr + k) % n;
            if (k < n && elig[i]) begin
                p.found = 1'b1;
                p.idx   = IDX_W'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/zip_add_arbiter_if.sv
// zip_add_arbiter_if: requester, datapath and response signals of the zip/add arbiter.
interface zip_add_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0]       req_a_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ-1:0]       req_b_valid;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;
    logic                   dp_valid;
    logic [WIDTH-1:0]       dp_a;
    logic [WIDTH-1:0]       dp_b;
    logic                   dp_ready;
    logic                   dp_res_valid;
    logic [WIDTH-1:0]       dp_res;
    logic                   dp_res_ready;
    logic [N_REQ-1:0]       resp_valid;
    logic [WIDTH-1:0]       resp_data;
    logic [N_REQ-1:0]       resp_ready;
    logic                   busy;
    logic                   err;

    modport master (
        output req_a_valid, req_a, req_b_valid, req_b, dp_ready, dp_res_valid, dp_res, resp_ready,
        input  req_ready, dp_valid, dp_a, dp_b, dp_res_ready, resp_valid, resp_data, busy, err
    );

    modport slave (
        input  req_a_valid, req_a, req_b_valid, req_b, dp_ready, dp_res_valid, dp_res, resp_ready,
        output req_ready, dp_valid, dp_a, dp_b, dp_res_ready, resp_valid, resp_data, busy, err
    );
endinterface

// File: rtl/zip_add_arbiter_tag_fifo.sv
// zip_add_arbiter_tag_fifo: DEPTH x TAG_W synchronous FIFO holding the owner tag of each in-flight pair.
module zip_add_arbiter_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [TAG_W-1:0]         push_tag,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [TAG_W-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    always_comb begin
        full    = count[PTR_W];
        empty   = count == '0;
        head    = mem[rd_ptr];
        do_push = push && !full;
        do_pop  = pop && !empty;
    end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= push_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
        end
    end
endmodule

// File: rtl/zip_add_arbiter.sv
// zip_add_arbiter: round-robin zip arbiter sharing one A+B datapath among N_REQ requesters.
// Define ZIP_ARB_STICKY_EN to let a winner keep priority for up to MAX_BURST consecutive grants.
module zip_add_arbiter
    import zip_add_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MAX_BURST = 4
) (
    input logic              clk,
    input logic              rst,
    zip_add_arbiter_if.slave bus
);
    localparam int TAG_W = $clog2(N_REQ);
    localparam int PTR_W = $clog2(DEPTH);

    logic [TAG_W-1:0]   rr_ptr, next_ptr, head;
    logic [IDX_W-1:0]   winner;
    logic [MAX_REQ-1:0] elig;
    pick_t              pick;
    logic               slot_free, grant, full, empty, pop;
    logic               dp_valid_q, err_q;
    logic [WIDTH-1:0]   dp_a_q, dp_b_q;
    logic [PTR_W:0]     count;

    always_comb begin
        elig                = '0;
        elig[N_REQ-1:0]     = bus.req_a_valid & bus.req_b_valid;
        pick                = rr_pick(elig, N_REQ, int'(rr_ptr));
        winner              = pick.idx;
        slot_free           = !dp_valid_q || bus.dp_ready;
        grant               = slot_free && !full && pick.found;
        next_ptr            = (winner == IDX_W'(N_REQ - 1)) ? '0 : TAG_W'(winner + 1'b1);
        bus.req_ready       = grant ? N_REQ'(1) << winner : '0;
        bus.resp_valid      = (bus.dp_res_valid && !empty) ? N_REQ'(1) << head : '0;
        bus.dp_res_ready    = !empty && bus.resp_ready[head];
        bus.resp_data       = bus.dp_res;
        pop                 = bus.dp_res_valid && bus.dp_res_ready;
        bus.busy            = dp_valid_q || count != '0;
        bus.dp_valid        = dp_valid_q;
        bus.dp_a            = dp_a_q;
        bus.dp_b            = dp_b_q;
        bus.err             = err_q;
    end

`ifdef ZIP_ARB_STICKY_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0] burst, burst_nxt;
    // A nonzero burst means rr_ptr is still parked on the previous winner.
    always_comb burst_nxt = (burst != '0 && winner == IDX_W'(rr_ptr)) ? burst + 1'b1 : BW'(1);
`else
    logic unused_burst;
    assign unused_burst = MAX_BURST != 0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_valid_q <= 1'b0;
            dp_a_q     <= '0;
            dp_b_q     <= '0;
            rr_ptr     <= '0;
            err_q      <= 1'b0;
`ifdef ZIP_ARB_STICKY_EN
            burst      <= '0;
`endif
        end else begin
            if (grant) begin
                dp_valid_q <= 1'b1;
                dp_a_q     <= bus.req_a[winner*WIDTH +: WIDTH];
                dp_b_q     <= bus.req_b[winner*WIDTH +: WIDTH];
`ifdef ZIP_ARB_STICKY_EN
                rr_ptr     <= (burst_nxt == BW'(MAX_BURST)) ? next_ptr : TAG_W'(winner);
                burst      <= (burst_nxt == BW'(MAX_BURST)) ? '0 : burst_nxt;
`else
                rr_ptr     <= next_ptr;
`endif
            end else if (slot_free) begin
                dp_valid_q <= 1'b0;
            end
            if (bus.dp_res_valid && empty) err_q <= 1'b1;
        end
    end

    zip_add_arbiter_tag_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (grant),
        .push_tag (TAG_W'(winner)),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head),
        .count    (count)
    );
endmodule
